// File: rtl/gshare_ras_predictor.sv
// Fetch-stage predictor: gshare PHT of 2-bit counters, tagged BTB, and a
// circular return-address stack. Predicts combinationally from the fetch PC
// and trains from EX-stage branch resolution.
module gshare_ras_predictor #(
  parameter int IDX_W     = 5,
  parameter int GHR_W     = 5,
  parameter int BTB_IDX_W = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       PC,
  input  logic [31:0]       nextPC,
  input  logic [31:0]       jump_target,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              is_call,
  input  logic              is_return,
  input  logic              fetch_valid,
  input  logic              Branch_EX,
  input  logic              branchTaken_EX,
  input  logic [31:0]       PC_EX,
  input  logic [31:0]       branch_target_EX,
  input  logic [IDX_W-1:0]  pht_index_in,
  input  logic [GHR_W-1:0]  GHR_in,
  input  logic              mispredict_EX,
  output logic              prediction,
  output logic [31:0]       final_address,
  output logic [IDX_W-1:0]  pht_index,
  output logic [GHR_W-1:0]  GHR
);
  localparam int PHT_N = 1 << IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;
  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [31:0]      tgt;
  } btb_ent_t;

  logic [PHT_N-1:0][1:0]      pht;
  btb_ent_t                   btb [BTB_N];
  logic [RAS_DEPTH-1:0][31:0] ras;
  logic [RP_W-1:0]            ras_ptr;   // next free slot; top is ras_ptr-1
  logic [CNT_W-1:0]           ras_cnt;
  logic [GHR_W-1:0]           ghr_q;

  logic [BTB_IDX_W-1:0] fbi, rbi;
  logic                 btb_hit;
  logic [31:0]          ras_top;
  logic                 ras_empty;
  logic                 unused_bits;

  assign GHR       = ghr_q;
  assign pht_index = PC[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign fbi       = PC[BTB_IDX_W+1:2];
  assign rbi       = PC_EX[BTB_IDX_W+1:2];
  assign btb_hit   = btb[fbi].vld && (btb[fbi].tag == PC[31:BTB_IDX_W+2]);
  assign ras_top   = ras[ras_ptr - 1'b1];
  assign ras_empty = (ras_cnt == '0);
  assign unused_bits = ^{PC[1:0], PC_EX[1:0], GHR_in[GHR_W-1]};

  // Next-fetch selection: jump > return > conditional branch > fall-through.
  always_comb begin
    prediction    = 1'b0;
    final_address = nextPC;
    if (is_jump) begin
      prediction    = 1'b1;
      final_address = jump_target;
    end else if (is_return) begin
      if (!ras_empty) begin
        prediction    = 1'b1;
        final_address = ras_top;
      end
    end else if (is_branch) begin
      if (pht[pht_index][1] && btb_hit) begin
        prediction    = 1'b1;
        final_address = btb[fbi].tgt;
      end
    end
  end

  // Global history: repair from the EX snapshot wins over speculative shift.
  always_ff @(posedge clk) begin
    if (Reset)
      ghr_q <= '0;
    else if (mispredict_EX && Branch_EX)
      ghr_q <= {GHR_in[GHR_W-2:0], branchTaken_EX};
    else if (fetch_valid && is_branch && !mispredict_EX)
      ghr_q <= {ghr_q[GHR_W-2:0], prediction};
  end

  // PHT training: saturating 2-bit counters, reset to weakly not-taken.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (Branch_EX) begin
      if (branchTaken_EX && pht[pht_index_in] != 2'b11)
        pht[pht_index_in] <= pht[pht_index_in] + 2'b01;
      else if (!branchTaken_EX && pht[pht_index_in] != 2'b00)
        pht[pht_index_in] <= pht[pht_index_in] - 2'b01;
    end
  end

  // BTB allocation on taken resolution only; reset clears valid bits.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < BTB_N; i++) btb[i].vld <= 1'b0;
    end else if (Branch_EX && branchTaken_EX) begin
      btb[rbi] <= '{vld: 1'b1, tag: PC_EX[31:BTB_IDX_W+2], tgt: branch_target_EX};
    end
  end

  // RAS: push on call (overwrites oldest when full), pop on return if non-empty.
  always_ff @(posedge clk) begin
    if (Reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (fetch_valid && is_call) begin
      ras[ras_ptr] <= nextPC;
      ras_ptr      <= ras_ptr + 1'b1;
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (fetch_valid && is_return && !ras_empty) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end
endmodule

// File: doc/gshare_ras_predictor.md
Name: gshare_ras_predictor

Overview:
- Parametrised next-generation fetch-stage branch predictor: gshare PHT (2-bit counters), tagged BTB and return-address stack (RAS).
- Sits beside the fetch PC mux: selects the next fetch address the same cycle it sees the PC; trains from EX-stage resolution.
- Adds over the current unit: configurable table and history sizes, BTB tags, call/return prediction, fetch-stall gating, GHR repair on mispredict.

Parameters:
- IDX_W, 5, PHT index width; PHT holds 2^IDX_W counters.
- GHR_W, 5, global history length; legal range 2 to IDX_W.
- BTB_IDX_W, 5, BTB index width; BTB holds 2^BTB_IDX_W entries.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  32  fetch PC.
- nextPC  in  32  PC+4.
- jump_target  in  32  decoded J/JAL target.
- is_branch, is_jump, is_call, is_return  in  1 each  decoded class of the fetched instruction; is_call is asserted together with is_jump.
- fetch_valid  in  1  fetch advances this cycle; low means stall, and all speculative state holds.
- Branch_EX  in  1  a conditional branch resolves in EX.
- branchTaken_EX  in  1  actual outcome.
- PC_EX  in  32  PC of the resolving branch.
- branch_target_EX  in  32  computed target.
- pht_index_in  in  IDX_W  PHT index carried down the pipe.
- GHR_in  in  GHR_W  GHR snapshot carried down the pipe.
- mispredict_EX  in  1  resolution disagrees with the prediction.
- prediction  out  1  predicted redirect: taken branch, jump, or return.
- final_address  out  32  next fetch address.
- pht_index  out  IDX_W  index used this cycle.
- GHR  out  GHR_W  history before this cycle's update.

Behaviour:
- Fetch path (combinational):
  - pht_index = PC[IDX_W+1:2] XOR zero-extended GHR.
  - BTB hit = valid[PC[BTB_IDX_W+1:2]] AND tag match, where tag = PC[31:BTB_IDX_W+2].
- Fetch priority:
  1. is_jump: final_address = jump_target, prediction = 1.
  2. is_return with RAS non-empty: final_address = RAS top, prediction = 1.
  3. is_return with RAS empty: final_address = nextPC, prediction = 0.
  4. is_branch: taken = PHT[pht_index][1] AND BTB hit; final_address = BTB target if taken, else nextPC; prediction = taken.
  5. Otherwise: final_address = nextPC, prediction = 0.
- Speculative GHR update: on the clock edge, if fetch_valid AND is_branch AND NOT mispredict_EX, then GHR <= {GHR[GHR_W-2:0], prediction}.
- Resolve, when Branch_EX:
  - PHT[pht_index_in] saturating increment if taken, decrement if not; range 00 to 11.
  - If taken: BTB[PC_EX index] <= valid, tag, branch_target_EX.
  - Not-taken resolution leaves the BTB unchanged.
- Mispredict repair: when mispredict_EX AND Branch_EX, GHR <= {GHR_in[GHR_W-2:0], branchTaken_EX}. Repair overrides any same-cycle speculative update.
- PHT/BTB read and write in the same cycle to the same entry: the read returns the old value; no bypass.
- RAS:
  - Circular buffer with top pointer and count (0 to RAS_DEPTH).
  - Push, when fetch_valid AND is_call: write nextPC, advance the pointer (wraps).
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop, when fetch_valid AND is_return AND count > 0: retreat the pointer, decrement count.
  - Pop when empty has no effect.
  - RAS is not repaired on mispredict; wrong-path calls/returns corrupt it by design.
- Reset (synchronous):
  - GHR = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - All BTB valid = 0.
  - RAS pointer and count = 0.
  - Resulting outputs for a branch fetch: prediction = 0, final_address = nextPC, GHR = 0.
  - Reset asserted mid-training discards all learned state.
- Latency:
  - Prediction: 0 cycles.
  - A training effect is visible at fetch on the cycle after the resolve edge.

Test Plan:
- Reset, then fetch_valid=1, is_branch=1, PC=0x40 -> prediction=0, final_address=0x44, GHR=0, pht_index=0x10.
- With fetch_valid=0, resolve PC_EX=0x40, pht_index_in=0x10, taken, target 0x100, twice (counter 01->10->11) -> fetch PC=0x40 with is_branch gives prediction=1, final_address=0x100.
- Resolve index 0x10 not-taken 5 times from 11 -> counter reaches 00 and stays; fetch gives final_address=0x44. Alias PC=0x1040 (same index, different tag) after taken training -> BTB miss, predicts nextPC.
- GHR=5'b10101; same cycle: mispredict_EX=1, Branch_EX=1, GHR_in=5'b00011, branchTaken_EX=1, and a fetch of a taken-predicted branch -> next GHR=5'b00111.
- RAS_DEPTH=4: calls at nextPC 0x204, 0x304, 0x404, 0x504, 0x604, then 5 returns -> return addresses 0x604, 0x504, 0x404, 0x304, then 5th return gives prediction=0, final_address=nextPC.
- is_jump=1 with a BTB hit and PHT=11 at the same PC, jump_target=0x800 -> final_address=0x800, prediction=1, GHR unchanged.
